demux_1x8_stream: RTL
=====================

Name: demux_1x8_stream

Overview:
- Registered 1-to-8 stream demultiplexer; the write-side counterpart of the team's 8:1 bus mux.
- Accepts one WIDTH-bit word per beat on a valid/ready input and routes it to exactly one of 8 output channels.
- The channel is either the explicit select or an internal round-robin pointer.
- Two-entry skid buffer gives full throughput; in_ready has no combinational path from out_ready.
- Sits between a single producer (DMA/ALU result bus) and eight consumer blocks.

Parameters:
- WIDTH, 32, width of data bus

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  input word
- in_sel  input  3  destination channel; used when rr_en=0
- rr_en  input  1  1 = use round-robin pointer instead of in_sel
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word this cycle
- out_data  output  WIDTH  word at head of buffer, shared by all channels
- out_valid  output  8  one-hot valid for the head word's channel; all-zero when empty
- out_ready  input  8  per-channel consumer ready
- out_chan  output  3  binary index of head word's channel; 0 when empty
- occupancy  output  2  words held: 0, 1 or 2

Behaviour:
- Reset (async, rst_n low):
  - Clear head/skid valid, head/skid data, head/skid channel and rr_ptr to 0.
  - out_valid=0, out_data=0, out_chan=0, occupancy=0.
  - in_ready forced 0 while rst_n is low. It is 1 from the first cycle after deassertion.
- Accept: in_valid && in_ready at a rising edge. in_ready = !skid_valid, from a registered term only.
- Channel capture at accept: ch = rr_en ? rr_ptr : in_sel.
  - rr_ptr increments by 1 per accepted beat only while rr_en=1, wrapping 7->0.
  - rr_ptr holds its value while rr_en=0.
- Release: head_valid && out_ready[head_ch] at a rising edge. out_ready bits of other channels are ignored.
- out_valid[i] = head_valid && (head_ch == i). out_data and out_chan come from the head register.
- States (occupancy):
  - EMPTY: accept -> ONE; the word is loaded into head and is visible the next cycle (latency 1).
  - ONE, accept and release -> ONE: head loads the new word.
  - ONE, accept only -> TWO: the new word goes to skid.
  - ONE, release only -> EMPTY.
  - TWO, release -> ONE: skid moves to head, skid clears. No accept is possible in TWO because in_ready=0.
- Strict in-order delivery across all channels. A stalled channel blocks later words for other channels (head-of-line blocking, by design).
- Head contents (data, channel) stay stable while head_valid=1 and the head is not released.
- Simultaneous accept and release in ONE sustains 1 word/cycle indefinitely.
- in_sel and rr_en are sampled only on accept; changes at other times have no effect.
- Reset mid-transfer discards both buffered words; no partial output appears after reset.
- Data in the skid and head registers is not cleared on release. Only the valid bits qualify it, except at reset.

Test Plan:
- Reset check: drive rst_n=0 mid-stream with occupancy=2. Required: out_valid=0, in_ready=0 and occupancy=0 immediately. After release of reset, in_ready=1 on the first edge and rr_ptr=0.
- Explicit routing: rr_en=0, send 0xA5A5_0003 with in_sel=3 while out_ready=8'hFF. Required: the next cycle shows out_valid=8'b0000_1000, out_chan=3, out_data=0xA5A5_0003, and the word clears on the following edge.
- Round-robin wrap: rr_en=1, push 10 words with data=i, out_ready=8'hFF. Required: channels 0..7, 0, 1 in order, data 0..9, one word per cycle, in_ready constantly 1.
- Backpressure and skid: out_ready=0, push 3 words (ch 5, 2, 6). Required: words 1 and 2 are accepted, occupancy=2, in_ready=0, and word 3 is held by the producer. Then set out_ready[5]=1. Required: word 1 releases, word 2 moves to head with out_valid=8'b0000_0100, and word 3 is accepted.
- Head-of-line blocking: head on ch 4 with out_ready=8'b1110_1111. Required: the head stays on ch 4 and out_data is stable for 20 cycles; no word reaches any other channel.
- Randomized scoreboard: random in_valid, out_ready, in_sel and rr_en over 10k cycles. Required: every word appears exactly once, in order, on its captured channel; out_valid is always zero or one-hot; occupancy never exceeds 2.

Source files
------------

// File: rtl/demux_1x8_stream.sv
// demux_1x8_stream: registered 1-to-8 stream demux with a two-entry skid buffer
module demux_1x8_stream #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             rr_en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [2:0]       out_chan,
  output logic [1:0]       occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [2:0]       head_ch_q, head_ch_d, skid_ch_q, skid_ch_d, rr_ptr_q, rr_ptr_d, ch;
  logic             head_v, acc, rel;
  assign head_v    = state_q != EMPTY;
  assign in_ready  = rst_n && state_q != TWO;
  assign acc       = in_valid && in_ready;
  assign rel       = head_v && out_ready[head_ch_q];
  assign ch        = rr_en ? rr_ptr_q : in_sel;
  assign out_data  = head_data_q;
  assign out_chan  = head_v ? head_ch_q : 3'd0;
  assign out_valid = head_v ? 8'd1 << head_ch_q : 8'd0;
  assign occupancy = state_q;
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ch_d   = head_ch_q;
    skid_data_d = skid_data_q;
    skid_ch_d   = skid_ch_q;
    rr_ptr_d    = (acc && rr_en) ? rr_ptr_q + 3'd1 : rr_ptr_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d     = ONE;
        head_data_d = in_data;
        head_ch_d   = ch;
      end
      ONE: if (acc && rel) begin
        head_data_d = in_data;
        head_ch_d   = ch;
      end else if (acc) begin
        state_d     = TWO;
        skid_data_d = in_data;
        skid_ch_d   = ch;
      end else if (rel) begin
        state_d = EMPTY;
      end
      TWO: if (rel) begin
        state_d     = ONE;
        head_data_d = skid_data_q;
        head_ch_d   = skid_ch_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_ch_q   <= '0;
      skid_data_q <= '0;
      skid_ch_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ch_q   <= head_ch_d;
      skid_data_q <= skid_data_d;
      skid_ch_q   <= skid_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end
endmodule
